// File: rtl/dsp_mac_sequencer_if.sv
// Job, operand and result handshakes between a requester and dsp_mac_sequencer.
// The requester side is the master; the sequencer side is the slave.
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             job_valid;
    logic             job_ready;
    logic [LEN_W-1:0] job_len;
    logic             op_valid;
    logic             op_ready;
    logic [17:0]      op_a;
    logic [17:0]      op_b;
    logic             res_valid;
    logic             res_ready;
    logic [47:0]      res_data;

    modport master (
        output job_valid, job_len, op_valid, op_a, op_b, res_ready,
        input  job_ready, op_ready, res_valid, res_data
    );

    modport slave (
        input  job_valid, job_len, op_valid, op_a, op_b, res_ready,
        output job_ready, op_ready, res_valid, res_data
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice as an unsigned 18x18 MAC: streams N operand pairs,
// time-aligns OPMODE through a tag pipe and returns the final P value.
module dsp_mac_sequencer #(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3,
    parameter int OPM_DLY  = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    dsp_mac_sequencer_if.slave bus,
    output logic [17:0]        DSP_A,
    output logic [17:0]        DSP_B,
    output logic [7:0]         DSP_OPMODE,
    output logic               DSP_RSTP,
    input  logic [47:0]        DSP_P
);
    localparam int TAG_D = PIPE_LAT + OPM_DLY;

    localparam logic [7:0] OPM_NEW  = 8'h01;
    localparam logic [7:0] OPM_ACC  = 8'h09;
    localparam logic [7:0] OPM_HOLD = 8'h08;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // acc marks a bubble inside a running sum so it still selects Z=P, X=M
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic acc;
    } tag_t;

    function automatic logic [7:0] opmode_of(input tag_t t);
        logic [7:0] opm;
        if (t.valid) begin
            opm = t.first ? OPM_NEW : OPM_ACC;
        end else begin
            opm = t.acc ? OPM_ACC : OPM_HOLD;
        end
        return opm;
    endfunction

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic [17:0]      a_q, a_d;
    logic [17:0]      b_q, b_d;
    logic [7:0]       opm_q, opm_d;
    logic             rstp_q;
    logic [47:0]      res_q, res_d;
    logic             job_ready_q, job_ready_d;
    logic             op_ready_q, op_ready_d;
    logic             res_valid_q, res_valid_d;
    tag_t             tag_q [TAG_D];
    tag_t             tag_in_s;

    // Next-state, operand slot and tag selection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        a_d      = 18'd0;
        b_d      = 18'd0;
        res_d    = res_q;
        tag_in_s = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.job_valid) begin
                    cnt_d   = bus.job_len;
                    first_d = 1'b1;
                    if (bus.job_len == LEN_W'(0)) begin
                        res_d   = 48'd0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (bus.op_valid) begin
                    a_d      = bus.op_a;
                    b_d      = bus.op_b;
                    tag_in_s = '{valid: 1'b1, first: first_q, last: (cnt_q == LEN_W'(1)), acc: 1'b0};
                    first_d  = 1'b0;
                    cnt_d    = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    tag_in_s = '{valid: 1'b0, first: 1'b0, last: 1'b0, acc: ~first_q};
                end
            end
            S_DRAIN: begin
                if (tag_q[TAG_D-1].valid && tag_q[TAG_D-1].last) begin
                    res_d   = DSP_P;
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        opm_d       = opmode_of(tag_q[OPM_DLY-1]);
        job_ready_d = (state_d == S_IDLE);
        op_ready_d  = (state_d == S_ISSUE);
        res_valid_d = (state_d == S_DONE);
    end

    // Control, datapath and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            a_q         <= 18'd0;
            b_q         <= 18'd0;
            opm_q       <= 8'd0;
            rstp_q      <= 1'b1;
            res_q       <= 48'd0;
            job_ready_q <= 1'b1;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            a_q         <= a_d;
            b_q         <= b_d;
            opm_q       <= opm_d;
            rstp_q      <= 1'b0;
            res_q       <= res_d;
            job_ready_q <= job_ready_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Tag pipe mirrors the slice latency; it runs every cycle like the slice
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < TAG_D; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in_s;
            for (int i = 1; i < TAG_D; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign DSP_A         = a_q;
    assign DSP_B         = b_q;
    assign DSP_OPMODE    = opm_q;
    assign DSP_RSTP      = rstp_q;
    assign bus.job_ready = job_ready_q;
    assign bus.op_ready  = op_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_q;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice
// (A1/B1, M, OPMODE and P registers) and a result scoreboard.
module tb_dsp_mac_sequencer;
    localparam int LEN_W    = 8;
    localparam int PIPE_LAT = 3;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [17:0] DSP_A, DSP_B;
    logic [7:0]  DSP_OPMODE;
    logic        DSP_RSTP;
    logic [47:0] DSP_P;

    dsp_mac_sequencer_if #(.LEN_W(LEN_W)) bus ();

    dsp_mac_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT), .OPM_DLY(1)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .bus        (bus),
        .DSP_A      (DSP_A),
        .DSP_B      (DSP_B),
        .DSP_OPMODE (DSP_OPMODE),
        .DSP_RSTP   (DSP_RSTP),
        .DSP_P      (DSP_P)
    );

    always #5 CLK = ~CLK;

    // Slice model: A1REG=B1REG=MREG=PREG=OPMODEREG=1, RSTP clears M and P
    logic [17:0] a1_q, b1_q;
    logic [35:0] m_q;
    logic [7:0]  opm_q;
    logic [47:0] p_q;
    always @(posedge CLK) begin
        a1_q  <= DSP_A;
        b1_q  <= DSP_B;
        opm_q <= DSP_OPMODE;
        if (DSP_RSTP) begin
            m_q <= 36'd0;
            p_q <= 48'd0;
        end else begin
            m_q <= a1_q * b1_q;
            p_q <= ((opm_q[3:2] == 2'b10) ? p_q : 48'd0)
                 + ((opm_q[1:0] == 2'b01) ? {12'd0, m_q} : 48'd0);
        end
    end
    assign DSP_P = p_q;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cnt01 = 0;
    logic [47:0] sb[$];
    logic [17:0] va [256];
    logic [17:0] vb [256];

    task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    always @(negedge CLK) begin
        if (DSP_OPMODE == 8'h01) cnt01++;
    end

    // Result monitor: compares every accepted result against the scoreboard
    always @(negedge CLK) begin
        if (RST_N && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL res_data: unexpected result %0d with empty scoreboard", bus.res_data);
            end else begin
                check("res_data", bus.res_data, sb.pop_front());
            end
        end
    end

    task automatic run_job(input int n, input int gap, input int hold, input logic [47:0] exp);
        int t;
        int c0;
        c0 = cnt01;
        sb.push_back(exp);
        bus.res_ready = (hold == 0);
        bus.job_valid = 1'b1;
        bus.job_len   = 8'(n);
        t = 0;
        @(negedge CLK);
        while (!bus.job_ready && t < 50) begin @(negedge CLK); t++; end
        check("job_accept", 48'(bus.job_ready), 48'd1);
        @(posedge CLK); #1;
        bus.job_valid = 1'b0;
        if (n == 0) begin
            check("n0_res_valid", 48'(bus.res_valid), 48'd1);
            check("n0_op_ready", 48'(bus.op_ready), 48'd0);
        end
        for (int i = 0; i < n; i++) begin
            bus.op_valid = 1'b1;
            bus.op_a     = va[i];
            bus.op_b     = vb[i];
            t = 0;
            @(negedge CLK);
            while (!bus.op_ready && t < 50) begin @(negedge CLK); t++; end
            if (i == 0 || !bus.op_ready) check("op_accept", 48'(bus.op_ready), 48'd1);
            if (!bus.op_ready) begin
                bus.op_valid = 1'b0;
                return;
            end
            @(posedge CLK); #1;
            bus.op_valid = 1'b0;
            if (i < n - 1) begin
                for (int g = 1; g <= gap; g++) begin
                    @(posedge CLK); #1;
                    check("bubble_a", 48'(DSP_A), 48'd0);
                    check("bubble_b", 48'(DSP_B), 48'd0);
                    if (g >= 2) check("bubble_opmode", 48'(DSP_OPMODE), 48'h09);
                end
            end
        end
        t = 0;
        while (!bus.res_valid && t < 50) begin @(posedge CLK); #1; t++; end
        if (n > 0) check("res_latency", 48'(t), 48'(PIPE_LAT + 1));
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(posedge CLK); #1;
                check("hold_valid", 48'(bus.res_valid), 48'd1);
                check("hold_data", bus.res_data, exp);
                check("hold_job_ready", 48'(bus.job_ready), 48'd0);
            end
            bus.res_ready = 1'b1;
        end
        t = 0;
        while (bus.res_valid && t < 50) begin @(posedge CLK); #1; t++; end
        check("res_release", 48'(bus.res_valid), 48'd0);
        check("first_opmode_count", 48'(cnt01 - c0), (n > 0) ? 48'd1 : 48'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dsp_a"}, 48'(DSP_A), 48'd0);
        check({tag, "_dsp_b"}, 48'(DSP_B), 48'd0);
        check({tag, "_opmode"}, 48'(DSP_OPMODE), 48'd0);
        check({tag, "_rstp"}, 48'(DSP_RSTP), 48'd1);
        check({tag, "_res_valid"}, 48'(bus.res_valid), 48'd0);
        check({tag, "_res_data"}, bus.res_data, 48'd0);
        check({tag, "_op_ready"}, 48'(bus.op_ready), 48'd0);
    endtask

    task automatic load_small();
        va[0] = 18'd2; vb[0] = 18'd3;
        va[1] = 18'd4; vb[1] = 18'd5;
        va[2] = 18'd6; vb[2] = 18'd7;
    endtask

    initial begin
        bus.job_valid = 1'b0;
        bus.job_len   = 8'd0;
        bus.op_valid  = 1'b0;
        bus.op_a      = 18'd0;
        bus.op_b      = 18'd0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST_N = 1'b1;
        @(posedge CLK); #1;
        check("rstp_release", 48'(DSP_RSTP), 48'd0);
        check("idle_job_ready", 48'(bus.job_ready), 48'd1);
        @(posedge CLK); #1;
        check("idle_opmode", 48'(DSP_OPMODE), 48'h08);

        // 2*3 + 4*5 + 6*7 = 68
        load_small();
        run_job(3, 0, 0, 48'd68);
        @(posedge CLK); #1;
        check("post_job_opmode", 48'(DSP_OPMODE), 48'h08);
        run_job(3, 2, 0, 48'd68);
        run_job(0, 0, 0, 48'd0);
        run_job(3, 0, 0, 48'd68);
        va[0] = 18'd1; vb[0] = 18'd1;
        run_job(1, 0, 0, 48'd1);

        // 255 * (2^18-1)^2 = 17523332874495
        for (int i = 0; i < 255; i++) begin
            va[i] = 18'h3FFFF;
            vb[i] = 18'h3FFFF;
        end
        run_job(255, 0, 0, 48'd17523332874495);

        load_small();
        run_job(3, 0, 5, 48'd68);

        // Abort a job mid-ISSUE; no result may appear for it
        bus.job_valid = 1'b1;
        bus.job_len   = 8'd3;
        @(negedge CLK);
        for (int t = 0; t < 50 && !bus.job_ready; t++) @(negedge CLK);
        @(posedge CLK); #1;
        bus.job_valid = 1'b0;
        bus.op_valid  = 1'b1;
        bus.op_a      = 18'd9;
        bus.op_b      = 18'd9;
        @(negedge CLK);
        check("abort_op_ready", 48'(bus.op_ready), 48'd1);
        @(posedge CLK); #1;
        bus.op_valid = 1'b0;
        RST_N = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        check("abort_rstp_release", 48'(DSP_RSTP), 48'd0);
        check("abort_job_ready", 48'(bus.job_ready), 48'd1);

        load_small();
        run_job(3, 1, 0, 48'd68);

        repeat (3) @(posedge CLK);
        check("scoreboard_empty", 48'(sb.size()), 48'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
